// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 32-bit ALU between two requesters. A three-state FSM
// (IDLE -> EXEC -> DONE) accepts one operation at a time, picks the
// requester round-robin when both ask in the same cycle, runs the ALU from
// latched operands, and presents the result until the consumer takes it.
//
// Parameters
//   MUL_LAT        EXEC cycles spent on a multiply (op 3'b101), 1..15
//
// Ports
//   clk_i          clock, rising edge active
//   rst_i          asynchronous active-high reset
//   req0_valid_i   requester 0 has an operation
//   req0_ready_o   requester 0 operation accepted this cycle
//   req0_op_i      requester 0 opcode (3 bits)
//   req0_src1_i    requester 0 operand 1 (32 bits)
//   req0_src2_i    requester 0 operand 2 (32 bits)
//   req1_*         same set of signals for requester 1
//   rsp_valid_o    result available
//   rsp_ready_i    consumer takes the result
//   rsp_id_o       index of the requester that owns the result
//   rsp_result_o   ALU result (32 bits)
//   busy_o         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_arbiter_alu
//
// Purely combinational ALU used by alu_arbiter.
//
// Ports
//   op_i    opcode: 000 AND, 001 XOR, 010 SLL, 011 ADD, 100 SUB,
//           101 MUL (low 32 bits), 110 ADD, 111 SRA
//   src1_i  operand 1, treated as signed
//   src2_i  operand 2, treated as signed; shifts use only bits [4:0]
//   res_o   32-bit wrap-around result
// ---------------------------------------------------------------------------
module alu_arbiter_alu (
    input  logic [2:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] res_o
);

    logic [4:0] shamt;

    assign shamt = src2_i[4:0];

    // The low 32 bits of a product are identical for signed and unsigned
    // interpretation, so a plain 32-bit multiply gives the wrapped result.
    // Only the arithmetic right shift needs the signed view of src1.
    always_comb begin
        res_o = 32'd0;
        case (op_i)
            3'b000:  res_o = src1_i & src2_i;
            3'b001:  res_o = src1_i ^ src2_i;
            3'b010:  res_o = src1_i << shamt;
            3'b011:  res_o = src1_i + src2_i;
            3'b100:  res_o = src1_i - src2_i;
            3'b101:  res_o = src1_i * src2_i;
            3'b110:  res_o = src1_i + src2_i;
            3'b111:  res_o = 32'($signed(src1_i) >>> shamt);
            default: res_o = 32'd0;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_src1_i,
    input  logic [31:0] req0_src2_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_src1_i,
    input  logic [31:0] req1_src2_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,

    output logic        busy_o
);

    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        last_grant_q;
    logic        grant;
    logic        accept;
    logic        exec_done;

    logic [2:0]  sel_op;
    logic [31:0] sel_src1;
    logic [31:0] sel_src2;
    logic [3:0]  cnt_load;

    logic [2:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic        id_q;
    logic [3:0]  cnt_q;

    logic [31:0] alu_res;

    // Round-robin pick: a lone valid requester always wins; on a tie the
    // requester that was not granted last time gets the slot. The result is
    // only meaningful when at least one valid is high, which is the only
    // time the FSM acts on it.
    always_comb begin
        grant = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant_q;
        end else if (req1_valid_i) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

    // Operand/opcode mux towards the capture registers; the ALU itself never
    // sees the request ports.
    assign sel_op   = grant ? req1_op_i   : req0_op_i;
    assign sel_src1 = grant ? req1_src1_i : req0_src1_i;
    assign sel_src2 = grant ? req1_src2_i : req0_src2_i;

    // The counter holds the number of EXEC cycles still to go after the
    // current one, so a value of zero marks the last EXEC cycle.
    assign cnt_load = (sel_op == OP_MUL) ? 4'(MUL_LAT - 1) : 4'd0;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and handshake decode. Readies are only raised in IDLE,
    // which also keeps a new accept out of the response handshake cycle.
    always_comb begin
        state_d      = state_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        accept       = 1'b0;
        exec_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    accept = 1'b1;
                    if (grant) begin
                        req1_ready_o = 1'b1;
                    end else begin
                        req0_ready_o = 1'b1;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    exec_done = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operation capture, arbitration history and the EXEC down-counter.
    // Everything here is cleared by reset so an operation in flight is simply
    // forgotten.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q         <= 3'd0;
            src1_q       <= 32'd0;
            src2_q       <= 32'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
        end else begin
            if (accept) begin
                op_q         <= sel_op;
                src1_q       <= sel_src1;
                src2_q       <= sel_src2;
                id_q         <= grant;
                last_grant_q <= grant;
                cnt_q        <= cnt_load;
            end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Response registers: loaded once on the last EXEC cycle and left alone
    // afterwards, so they stay stable for as long as the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_result_o <= 32'd0;
            rsp_id_o     <= 1'b0;
        end else if (exec_done) begin
            rsp_result_o <= alu_res;
            rsp_id_o     <= id_q;
        end
    end

    alu_arbiter_alu u_alu (
        .op_i   (op_q),
        .src1_i (src1_q),
        .src2_i (src2_q),
        .res_o  (alu_res)
    );

    assign rsp_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed, self-checking bench for alu_arbiter with MUL_LAT = 3. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge,
// away from the rising edge the design acts on. Each check is an immediate
// assertion against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [2:0]  req0_op_i;
    logic [31:0] req0_src1_i;
    logic [31:0] req0_src2_i;

    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [2:0]  req1_op_i;
    logic [31:0] req1_src1_i;
    logic [31:0] req1_src2_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [31:0] rsp_result_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b111;

    always #5 clk_i = ~clk_i;

    alu_arbiter #(
        .MUL_LAT (3)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_op_i    (req0_op_i),
        .req0_src1_i  (req0_src1_i),
        .req0_src2_i  (req0_src2_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_op_i    (req1_op_i),
        .req1_src1_i  (req1_src1_i),
        .req1_src2_i  (req1_src2_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .busy_o       (busy_o)
    );

    // Drive every request/response input at once, then let the
    // combinational readies settle before anything is sampled.
    task automatic applyStimulus(
        input logic        v0,
        input logic [2:0]  op0,
        input logic [31:0] a0,
        input logic [31:0] b0,
        input logic        v1,
        input logic [2:0]  op1,
        input logic [31:0] a1,
        input logic [31:0] b1,
        input logic        rr
    );
        req0_valid_i = v0;
        req0_op_i    = op0;
        req0_src1_i  = a0;
        req0_src2_i  = b0;
        req1_valid_i = v1;
        req1_op_i    = op1;
        req1_src1_i  = a1;
        req1_src2_i  = b1;
        rsp_ready_i  = rr;
        #1;
    endtask

    // One comparison: count it, and on a miss count and report it.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance by one full clock period, landing on the next falling edge.
    task automatic nextCycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b0);
        nextCycle();
        nextCycle();

        // Reset state.
        checkOutput("rst_rsp_valid", rsp_valid_o, 32'd0);
        checkOutput("rst_busy", busy_o, 32'd0);
        checkOutput("rst_result", rsp_result_o, 32'd0);
        checkOutput("rst_id", rsp_id_o, 32'd0);
        checkOutput("rst_ready0", req0_ready_o, 32'd0);
        checkOutput("rst_ready1", req1_ready_o, 32'd0);
        rst_i = 1'b0;

        // req0 ADD 5,7 alone: ready in T, response at T+2.
        $display("[TB] req0 ADD alone");
        applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        checkOutput("add_ready0_T", req0_ready_o, 32'd1);
        checkOutput("add_ready1_T", req1_ready_o, 32'd0);
        checkOutput("add_busy_T", busy_o, 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        checkOutput("add_busy_T1", busy_o, 32'd1);
        checkOutput("add_valid_T1", rsp_valid_o, 32'd0);
        checkOutput("add_ready0_T1", req0_ready_o, 32'd0);
        nextCycle();
        checkOutput("add_valid_T2", rsp_valid_o, 32'd1);
        checkOutput("add_result", rsp_result_o, 32'd12);
        checkOutput("add_id", rsp_id_o, 32'd0);
        nextCycle();
        checkOutput("add_valid_after", rsp_valid_o, 32'd0);
        checkOutput("add_busy_after", busy_o, 32'd0);

        // Both requesters valid all the time: a fresh reset makes req0 win the
        // first tie, then grants alternate 0,1,0,1.
        $display("[TB] round-robin SUB/XOR");
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(1'b1, OP_SUB, 32'd10, 32'd3, 1'b1, OP_XOR, 32'hF0, 32'hFF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr%0d_ready0", k), req0_ready_o, (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rr%0d_ready1", k), req1_ready_o, (k % 2 == 1) ? 32'd1 : 32'd0);
            nextCycle();
            checkOutput($sformatf("rr%0d_busy", k), busy_o, 32'd1);
            nextCycle();
            checkOutput($sformatf("rr%0d_valid", k), rsp_valid_o, 32'd1);
            checkOutput($sformatf("rr%0d_result", k), rsp_result_o, (k % 2 == 0) ? 32'd7 : 32'h0F);
            checkOutput($sformatf("rr%0d_id", k), rsp_id_o, (k % 2 == 0) ? 32'd0 : 32'd1);
            checkOutput($sformatf("rr%0d_hs_ready0", k), req0_ready_o, 32'd0);
            checkOutput($sformatf("rr%0d_hs_ready1", k), req1_ready_o, 32'd0);
            nextCycle();
        end

        // req1 MUL -3*4 with MUL_LAT=3: busy T+1..T+4, response at T+4.
        $display("[TB] req1 MUL");
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b1, OP_MUL, 32'hFFFF_FFFD, 32'd4, 1'b1);
        checkOutput("mul_ready1_T", req1_ready_o, 32'd1);
        checkOutput("mul_ready0_T", req0_ready_o, 32'd0);
        nextCycle();
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checkOutput($sformatf("mul_busy_T%0d", c), busy_o, 32'd1);
            checkOutput($sformatf("mul_valid_T%0d", c), rsp_valid_o, 32'd0);
            nextCycle();
        end
        checkOutput("mul_valid_T4", rsp_valid_o, 32'd1);
        checkOutput("mul_busy_T4", busy_o, 32'd1);
        checkOutput("mul_result", rsp_result_o, 32'hFFFF_FFF4);
        checkOutput("mul_id", rsp_id_o, 32'd1);
        nextCycle();
        checkOutput("mul_busy_after", busy_o, 32'd0);

        // SRA 0x80000000 by 33 (shift of 1) with the consumer stalling; both
        // requesters keep asking. last_grant is 1, so req0 takes the tie.
        $display("[TB] SRA with stalled consumer");
        applyStimulus(1'b1, OP_SRA, 32'h8000_0000, 32'd33, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0);
        checkOutput("sra_ready0_T", req0_ready_o, 32'd1);
        checkOutput("sra_ready1_T", req1_ready_o, 32'd0);
        nextCycle();
        nextCycle();
        for (int s = 0; s < 5; s++) begin
            checkOutput($sformatf("sra_stall%0d_valid", s), rsp_valid_o, 32'd1);
            checkOutput($sformatf("sra_stall%0d_result", s), rsp_result_o, 32'hC000_0000);
            checkOutput($sformatf("sra_stall%0d_id", s), rsp_id_o, 32'd0);
            checkOutput($sformatf("sra_stall%0d_ready0", s), req0_ready_o, 32'd0);
            checkOutput($sformatf("sra_stall%0d_ready1", s), req1_ready_o, 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, OP_SRA, 32'h8000_0000, 32'd33, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b1);
        checkOutput("sra_hs_valid", rsp_valid_o, 32'd1);
        checkOutput("sra_hs_ready0", req0_ready_o, 32'd0);
        checkOutput("sra_hs_ready1", req1_ready_o, 32'd0);
        nextCycle();
        // Back in IDLE: the waiting tie now goes to req1, but the requests
        // are withdrawn before the edge so nothing is accepted.
        checkOutput("sra_post_ready1", req1_ready_o, 32'd1);
        checkOutput("sra_post_ready0", req0_ready_o, 32'd0);
        checkOutput("sra_post_busy", busy_o, 32'd0);
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        nextCycle();
        checkOutput("sra_idle_busy", busy_o, 32'd0);
        checkOutput("sra_result_held", rsp_result_o, 32'hC000_0000);

        // Reset in the middle of a MUL: outputs clear without a clock edge and
        // no response ever appears for the dropped operation.
        $display("[TB] reset during MUL");
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b1, OP_MUL, 32'd7, 32'd9, 1'b1);
        checkOutput("rstmul_ready1", req1_ready_o, 32'd1);
        nextCycle();
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        checkOutput("rstmul_busy", busy_o, 32'd1);
        nextCycle();
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("rstmul_async_busy", busy_o, 32'd0);
        checkOutput("rstmul_async_valid", rsp_valid_o, 32'd0);
        checkOutput("rstmul_async_result", rsp_result_o, 32'd0);
        checkOutput("rstmul_async_id", rsp_id_o, 32'd0);
        nextCycle();
        rst_i = 1'b0;
        for (int w = 0; w < 4; w++) begin
            checkOutput($sformatf("rstmul_quiet%0d", w), rsp_valid_o, 32'd0);
            nextCycle();
        end

        // First request after reset is accepted on its first edge.
        applyStimulus(1'b1, OP_SLL, 32'd1, 32'd4, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        checkOutput("sll_ready0", req0_ready_o, 32'd1);
        nextCycle();
        applyStimulus(1'b0, OP_AND, 32'd0, 32'd0, 1'b0, OP_AND, 32'd0, 32'd0, 1'b1);
        nextCycle();
        checkOutput("sll_valid", rsp_valid_o, 32'd1);
        checkOutput("sll_result", rsp_result_o, 32'd16);
        checkOutput("sll_id", rsp_id_o, 32'd0);
        nextCycle();
        checkOutput("sll_busy_after", busy_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
